srm_controller: RTL and testbench

- Multi-cycle control FSM that sits directly upstream of the 8x16 register file.
- Latches a 16-bit instruction, decodes it, and sequences the register file's readnum/writenum/write together with the datapath strobes (loada, loadb, loadc, loads, asel, vsel, shift, ALUop).
- Executes one instruction per start pulse and signals completion on w.

---
 rtl/srm_controller.sv | 130 +++++++++++++
 tb/tb_srm_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/srm_controller.sv
// srm_controller: multi-cycle control FSM sequencing the 8x16 register file and datapath strobes
//
// Executes one instruction per start pulse. The instruction is latched into ir
// when s=1 in WAIT; all outputs are Moore, decoded from state and ir only.
//
// Ports:
//   clk       in   1   clock, all state updates on posedge
//   reset_n   in   1   synchronous active-low reset
//   s         in   1   start, sampled only in WAIT
//   in        in   16  instruction, latched on start
//   w         out  1   high iff in WAIT
//   readnum   out  3   register file read select
//   writenum  out  3   register file write select
//   write     out  1   register file write enable
//   loada     out  1   load datapath A register
//   loadb     out  1   load datapath B register
//   loadc     out  1   load datapath C register
//   loads     out  1   load status flags
//   asel      out  1   force ALU A input to zero
//   vsel      out  2   writeback mux: 00 C, 01 sximm8
//   shift     out  2   shifter control
//   ALUop     out  2   ALU operation
//   sximm8    out  16  sign-extended imm8 of ir
module srm_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_WRITE_IMM
  } state_t;
  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic        is_cmp;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign is_cmp = ir_q[15:11] == 5'b10101;
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        ir_d    = s ? in : ir_q;
        state_d = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        case (ir_q[15:11])
          5'b11010:                   state_d = S_WRITE_IMM;
          5'b11000, 5'b10111:         state_d = S_GET_B;
          5'b10100, 5'b10101, 5'b10110: state_d = S_GET_A;
          default:                    state_d = S_WAIT;
        endcase
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_GET_A: begin
        readnum = ir_q[10:8];
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = ir_q[2:0];
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = ir_q[4:3];
        ALUop = opcode == 3'b101 ? op : 2'b00;
        asel  = opcode == 3'b110;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WRITE_REG: begin
        writenum = ir_q[7:5];
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = ir_q[10:8];
        vsel     = 2'b01;
        write    = 1'b1;
      end
      default: w = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_srm_controller.sv
// tb_srm_controller: scoreboard bench for srm_controller with directed instructions
module tb_srm_controller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s = 1'b1;
  logic [15:0] in_v = 16'hD007;
  logic        w, write, loada, loadb, loadc, loads, asel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;
  logic [34:0] q[$];
  logic [34:0] act, e;
  int total = 0;
  int bad = 0;
  srm_controller dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in_v), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .vsel(vsel), .shift(shift), .ALUop(ALUop), .sximm8(sximm8)
  );
  always #5 clk = ~clk;
  function automatic logic [34:0] mk(input logic wv, input logic [2:0] rn, input logic [2:0] wn,
    input logic wr, input logic la, input logic lb, input logic lc, input logic ls,
    input logic as, input logic [1:0] vs, input logic [1:0] sh, input logic [1:0] op,
    input logic [15:0] sx);
    return {wv, rn, wn, wr, la, lb, lc, ls, as, vs, sh, op, sx};
  endfunction
  function automatic logic [34:0] idle(input logic wv, input logic [15:0] sx);
    return mk(wv, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, sx);
  endfunction
  assign act = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, shift, ALUop, sximm8};
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL out_vec t=%0t actual=%h required=%h", $time, act, e);
      end
    end
  end
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
      q.delete();
    end
  endtask
  task automatic start(input logic [15:0] ins);
    s = 1'b1;
    in_v = ins;
    @(posedge clk);
  endtask
  initial begin
    // reset held two edges with s=1: WAIT, ir cleared
    repeat (2) begin
      @(posedge clk);
      q.push_back(idle(1, 16'h0000));
      @(negedge clk);
    end
    #1 reset_n = 1'b1;
    // first edge after release latches D007 (MOV R0,#7)
    start(16'hD007);
    q.push_back(idle(0, 16'h0007));
    q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 16'h0007));
    q.push_back(idle(1, 16'h0007));
    #1 s = 1'b0;
    drain();
    // MOV R1,#-2
    start(16'hD1FE);
    q.push_back(idle(0, 16'hFFFE));
    q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 16'hFFFE));
    q.push_back(idle(1, 16'hFFFE));
    #1 s = 1'b0;
    drain();
    // ADD R2,R1,R0 LSL#1
    start(16'hA148);
    q.push_back(idle(0, 16'h0048));
    q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0048));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0048));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 16'h0048));
    q.push_back(mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0048));
    q.push_back(idle(1, 16'h0048));
    #1 s = 1'b0;
    drain();
    // CMP R0,R1
    start(16'hA801);
    q.push_back(idle(0, 16'h0001));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0001));
    q.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0001));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 16'h0001));
    q.push_back(idle(1, 16'h0001));
    #1 s = 1'b0;
    drain();
    // MOV R3,R2
    start(16'hC062);
    q.push_back(idle(0, 16'h0062));
    q.push_back(mk(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0062));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 16'h0062));
    q.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0062));
    q.push_back(idle(1, 16'h0062));
    #1 s = 1'b0;
    drain();
    // MVN R4,R5 LSR
    start(16'hB895);
    q.push_back(idle(0, 16'hFF95));
    q.push_back(mk(0, 5, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFF95));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b11, 16'hFF95));
    q.push_back(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFF95));
    q.push_back(idle(1, 16'hFF95));
    #1 s = 1'b0;
    drain();
    // AND R5,R3,R6
    start(16'hB3A6);
    q.push_back(idle(0, 16'hFFA6));
    q.push_back(mk(0, 3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA6));
    q.push_back(mk(0, 6, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA6));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10, 16'hFFA6));
    q.push_back(mk(0, 0, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA6));
    q.push_back(idle(1, 16'hFFA6));
    #1 s = 1'b0;
    drain();
    // illegal opcodes: DECODE then WAIT, no strobes
    start(16'hE000);
    q.push_back(idle(0, 16'h0000));
    q.push_back(idle(1, 16'h0000));
    #1 s = 1'b0;
    drain();
    start(16'hC8F0);
    q.push_back(idle(0, 16'hFFF0));
    q.push_back(idle(1, 16'hFFF0));
    #1 s = 1'b0;
    drain();
    // s low in WAIT: stays idle
    @(posedge clk);
    q.push_back(idle(1, 16'hFFF0));
    drain();
    // ADD aborted by reset during the ALU cycle
    start(16'hA148);
    q.push_back(idle(0, 16'h0048));
    q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0048));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0048));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 16'h0048));
    #1 s = 1'b0;
    drain();
    reset_n = 1'b0;
    @(posedge clk);
    q.push_back(idle(1, 16'h0000));
    drain();
    reset_n = 1'b1;
    @(posedge clk);
    q.push_back(idle(1, 16'h0000));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
